// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - Shared encodings for the multi-cycle MIPS control FSM
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_R_EXEC    = 4'd2,
      S_R_WB      = 4'd3,
      S_I_EXEC    = 4'd4,
      S_I_WB      = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WB    = 4'd8,
      S_MEM_WRITE = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_JAL       = 4'd12,
      S_ERROR     = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] REG_RT  = 2'b00;
   localparam logic [1:0] REG_RD  = 2'b01;
   localparam logic [1:0] REG_R31 = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   localparam logic [1:0] B_REG     = 2'b00;
   localparam logic [1:0] B_FOUR    = 2'b01;
   localparam logic [1:0] B_IMM     = 2'b10;
   localparam logic [1:0] B_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - ALU operation decode from opcode/funct with illegal-funct detect
module mips_alu_dec
   import mips_mc_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctrl_o,
   output logic       illegal_funct_o
);

   always_comb begin
      alu_ctrl_o      = ALU_ADD;
      illegal_funct_o = 1'b0;
      if (opcode_i == OP_RTYPE) begin
         case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: illegal_funct_o = 1'b1;
         endcase
      end else begin
         case (opcode_i)
            OP_ANDI: alu_ctrl_o = ALU_AND;
            OP_ORI:  alu_ctrl_o = ALU_OR;
            OP_SLTI: alu_ctrl_o = ALU_SLT;
            default: alu_ctrl_o = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - Main control FSM of the multi-cycle MIPS core
module mips_mc_ctrl
   import mips_mc_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [4:0]       ir_rt,
   input  logic [4:0]       ir_rd,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             rf_we,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             ext_zero,
   output logic [3:0]       alu_ctrl,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic             bus_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q;
   logic              illegal_q, bus_err_q;
   logic              set_illegal, set_bus_err, timeout;
   logic [CNT_W-1:0]  cycle_q, instret_q;
   logic [3:0]        dec_alu_ctrl;
   logic              dec_illegal;
   logic [4:0]        dest;

   mips_alu_dec u_alu_dec (
      .opcode_i        (opcode),
      .funct_i         (funct),
      .alu_ctrl_o      (dec_alu_ctrl),
      .illegal_funct_o (dec_illegal)
   );

   // wait_q counts the mem_ready-low cycles already spent; this cycle would be the last allowed
   assign timeout = (TIMEOUT_CYC != 0) && !mem_ready && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d     = state_q;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_ALU;
      iord        = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      ir_we       = 1'b0;
      reg_dst     = REG_RT;
      mem_to_reg  = WB_ALUOUT;
      rf_we       = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = B_REG;
      ext_zero    = 1'b0;
      alu_ctrl    = ALU_AND;
      dest        = 5'd0;
      case (state_q)
         S_FETCH: begin
            mem_rd    = 1'b1;
            alu_src_b = B_FOUR;
            alu_ctrl  = ALU_ADD;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               set_bus_err = 1'b1;
               state_d     = S_ERROR;
            end
         end
         S_DECODE: begin
            alu_src_b = B_IMM_SH2;
            alu_ctrl  = ALU_ADD;
            case (opcode)
               OP_RTYPE:                          state_d = S_R_EXEC;
               OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
               OP_J:                              state_d = S_JUMP;
               OP_JAL:                            state_d = S_JAL;
               default: begin
                  set_illegal = 1'b1;
                  state_d     = S_ERROR;
               end
            endcase
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_ctrl  = dec_alu_ctrl;
            if (dec_illegal) begin
               set_illegal = 1'b1;
               state_d     = S_ERROR;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_R_WB: begin
            reg_dst = REG_RD;
            rf_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = B_IMM;
            alu_ctrl  = dec_alu_ctrl;
            ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI);
            state_d   = S_I_WB;
         end
         S_I_WB: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = B_IMM;
            alu_ctrl  = ALU_ADD;
            state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ, S_MEM_WRITE: begin
            iord   = 1'b1;
            mem_rd = (state_q == S_MEM_READ);
            mem_wr = (state_q == S_MEM_WRITE);
            if (mem_ready) begin
               state_d = (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
            end else if (timeout) begin
               set_bus_err = 1'b1;
               state_d     = S_ERROR;
            end
         end
         S_MEM_WB: begin
            mem_to_reg = WB_MDR;
            rf_we      = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_we     = (opcode == OP_BEQ) ? zero : ~zero;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = PC_JUMP;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            pc_src     = PC_JUMP;
            pc_we      = 1'b1;
            reg_dst    = REG_R31;
            mem_to_reg = WB_PC;
            rf_we      = 1'b1;
            state_d    = S_FETCH;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase

      case (reg_dst)
         REG_RT:  dest = ir_rt;
         REG_RD:  dest = ir_rd;
         default: dest = 5'd31;
      endcase
      if (dest == 5'd0) rf_we = 1'b0;

      // Controls are silenced for the whole time reset is held, not only at the next edge
      if (!rst_n) begin
         pc_we      = 1'b0;
         pc_src     = PC_ALU;
         iord       = 1'b0;
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         ir_we      = 1'b0;
         reg_dst    = REG_RT;
         mem_to_reg = WB_ALUOUT;
         rf_we      = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = B_REG;
         ext_zero   = 1'b0;
         alu_ctrl   = ALU_AND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_q + CNT_W'(1);
         if (state_d != state_q) wait_q <= '0;
         else if (!mem_ready)    wait_q <= wait_q + WAIT_W'(1);
         if (state_d == S_FETCH && state_q != S_FETCH) instret_q <= instret_q + CNT_W'(1);
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
      end
   end

   assign state       = state_q;
   assign illegal_op  = illegal_q;
   assign bus_err     = bus_err_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - Randomized self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;
   import mips_mc_pkg::*;

   localparam int TO = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    opcode = '0, funct = '0;
   logic [4:0]    ir_rt = '0, ir_rd = '0;
   logic          zero = 1'b0, mem_ready = 1'b0;
   logic          pc_we, iord, mem_rd, mem_wr, ir_we, rf_we, alu_src_a, ext_zero;
   logic [1:0]    pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [3:0]    alu_ctrl, state;
   logic          illegal_op, bus_err;
   logic [CW-1:0] cycle_cnt, instret_cnt;

   mips_mc_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .ir_rt(ir_rt), .ir_rd(ir_rd),
      .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .rf_we(rf_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
      .alu_ctrl(alu_ctrl), .state(state), .illegal_op(illegal_op), .bus_err(bus_err),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       iord, mem_rd, mem_wr, ir_we;
      logic [1:0] reg_dst, mem_to_reg;
      logic       rf_we, alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [3:0] alu_ctrl;
   } ctl_t;

   ctl_t exp_q[$];
   logic mr_q[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0, ret = 0;
   logic [5:0] ops [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                            6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b000011};
   logic [5:0] fns [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   function automatic ctl_t blank(input logic [3:0] st);
      ctl_t r = '0;
      r.st = st;
      return r;
   endfunction

   function automatic ctl_t obs();
      ctl_t r;
      r.st = state; r.pc_we = pc_we; r.pc_src = pc_src; r.iord = iord; r.mem_rd = mem_rd;
      r.mem_wr = mem_wr; r.ir_we = ir_we; r.reg_dst = reg_dst; r.mem_to_reg = mem_to_reg;
      r.rf_we = rf_we; r.alu_src_a = alu_src_a; r.alu_src_b = alu_src_b; r.ext_zero = ext_zero;
      r.alu_ctrl = alu_ctrl;
      return r;
   endfunction

   function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         default:   return 4'b0111;
      endcase
   endfunction

   task automatic push(input ctl_t c, input logic mr);
      exp_q.push_back(c);
      mr_q.push_back(mr);
   endtask

   task automatic build_front(input int wf);
      ctl_t c;
      exp_q.delete();
      mr_q.delete();
      c = blank(S_FETCH); c.mem_rd = 1; c.alu_src_b = 2'b01; c.alu_ctrl = 4'b0010;
      repeat (wf) push(c, 1'b0);
      c.ir_we = 1; c.pc_we = 1;
      push(c, 1'b1);
      c = blank(S_DECODE); c.alu_src_b = 2'b11; c.alu_ctrl = 4'b0010;
      push(c, 1'($urandom));
   endtask

   task automatic play(input string nm);
      ctl_t o;
      for (int i = 0; i < exp_q.size(); i++) begin
         mem_ready = mr_q[i];
         @(negedge clk);
         o = obs();
         n_cmp++;
         if (o !== exp_q[i]) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", nm, i, o, exp_q[i]);
         end
         @(posedge clk);
         cyc++;
         #1;
      end
   endtask

   task automatic check_counters(input string nm);
      logic [CW-1:0] ec, er;
      ec = cyc[CW-1:0];
      er = ret[CW-1:0];
      n_cmp++;
      if (cycle_cnt !== ec || instret_cnt !== er) begin
         n_err++;
         $display("FAIL %s counters: got cyc=%0d ret=%0d want cyc=%0d ret=%0d", nm, cycle_cnt, instret_cnt, ec, er);
      end
   endtask

   task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rt, input logic [4:0] rd, input logic z,
                            input int wf, input int wm);
      ctl_t c;
      opcode = op; funct = fn; ir_rt = rt; ir_rd = rd; zero = z;
      build_front(wf);
      if (op == 6'b000000) begin
         c = blank(S_R_EXEC); c.alu_src_a = 1; c.alu_ctrl = alu_of_funct(fn); push(c, 1'($urandom));
         c = blank(S_R_WB); c.reg_dst = 2'b01; c.rf_we = (rd != 0); push(c, 1'($urandom));
      end else if (op == 6'b100011 || op == 6'b101011) begin
         c = blank(S_MEM_ADDR); c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 4'b0010;
         push(c, 1'($urandom));
         c = blank(op == 6'b100011 ? S_MEM_READ : S_MEM_WRITE); c.iord = 1;
         c.mem_rd = (op == 6'b100011); c.mem_wr = (op == 6'b101011);
         repeat (wm) push(c, 1'b0);
         push(c, 1'b1);
         if (op == 6'b100011) begin
            c = blank(S_MEM_WB); c.mem_to_reg = 2'b01; c.rf_we = (rt != 0); push(c, 1'($urandom));
         end
      end else if (op == 6'b000100 || op == 6'b000101) begin
         c = blank(S_BRANCH); c.alu_src_a = 1; c.alu_ctrl = 4'b0110; c.pc_src = 2'b01;
         c.pc_we = (op == 6'b000100) ? z : !z;
         push(c, 1'($urandom));
      end else if (op == 6'b000010) begin
         c = blank(S_JUMP); c.pc_src = 2'b10; c.pc_we = 1; push(c, 1'($urandom));
      end else if (op == 6'b000011) begin
         c = blank(S_JAL); c.pc_src = 2'b10; c.pc_we = 1; c.reg_dst = 2'b10;
         c.mem_to_reg = 2'b10; c.rf_we = 1; push(c, 1'($urandom));
      end else begin
         c = blank(S_I_EXEC); c.alu_src_a = 1; c.alu_src_b = 2'b10;
         c.alu_ctrl = (op == 6'b001100) ? 4'b0000 : (op == 6'b001101) ? 4'b0001 :
                      (op == 6'b001010) ? 4'b0111 : 4'b0010;
         c.ext_zero = (op == 6'b001100) || (op == 6'b001101);
         push(c, 1'($urandom));
         c = blank(S_I_WB); c.rf_we = (rt != 0); push(c, 1'($urandom));
      end
      play(nm);
      ret++;
      n_cmp++;
      if (state !== S_FETCH) begin
         n_err++;
         $display("FAIL %s end_state: got %0d want %0d", nm, state, S_FETCH);
      end
      check_counters(nm);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cyc = 0;
      ret = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1;
         opcode = 6'($urandom);
         @(negedge clk);
         n_cmp++;
         if (obs() !== blank(S_FETCH) || illegal_op !== 0 || bus_err !== 0 ||
             cycle_cnt !== '0 || instret_cnt !== '0) begin
            n_err++;
            $display("FAIL reset: got ctl=%h flags=%b%b cnt=%0d/%0d want ctl=%h zeros", obs(),
                     illegal_op, bus_err, cycle_cnt, instret_cnt, blank(S_FETCH));
         end
      end
      do_reset();
   endtask

   task automatic test_directed();
      run_instr("lw_wait", 6'b100011, 6'h00, 5'd8, 5'd0, 1'b0, 2, 0);
      run_instr("add_rd5", 6'b000000, 6'b100000, 5'd3, 5'd5, 1'b0, 0, 0);
      run_instr("add_rd0", 6'b000000, 6'b100000, 5'd3, 5'd0, 1'b0, 0, 0);
      run_instr("beq_z1", 6'b000100, 6'h00, 5'd1, 5'd2, 1'b1, 0, 0);
      run_instr("beq_z0", 6'b000100, 6'h00, 5'd1, 5'd2, 1'b0, 0, 0);
      run_instr("bne_z0", 6'b000101, 6'h00, 5'd1, 5'd2, 1'b0, 0, 0);
      run_instr("bne_z1", 6'b000101, 6'h00, 5'd1, 5'd2, 1'b1, 0, 0);
      run_instr("jal", 6'b000011, 6'h00, 5'd0, 5'd0, 1'b0, 0, 0);
      run_instr("sw_edge", 6'b101011, 6'h00, 5'd4, 5'd0, 1'b0, TO - 1, TO - 1);
   endtask

   task automatic test_random();
      logic [5:0] op;
      logic [4:0] rt, rd;
      for (int n = 0; n < 60; n++) begin
         op = ops[$urandom_range(0, 10)];
         rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         run_instr("random", op, fns[$urandom_range(0, 4)], rt, rd, 1'($urandom),
                   $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
      end
   endtask

   task automatic test_illegal_funct();
      ctl_t c;
      do_reset();
      opcode = 6'b000000; funct = 6'b000000; ir_rd = 5'd9;
      build_front(0);
      play("ill_funct");
      mem_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (state !== S_R_EXEC) begin
         n_err++;
         $display("FAIL ill_funct exec: got %0d want %0d", state, S_R_EXEC);
      end
      @(posedge clk); cyc++; #1;
      c = blank(S_ERROR);
      n_cmp++;
      if (obs() !== c || illegal_op !== 1'b1 || bus_err !== 1'b0) begin
         n_err++;
         $display("FAIL ill_funct error: got ctl=%h ill=%b bus=%b want ctl=%h ill=1 bus=0", obs(),
                  illegal_op, bus_err, c);
      end
   endtask

   task automatic test_illegal_op();
      do_reset();
      opcode = 6'b111111;
      build_front($urandom_range(0, TO - 1));
      play("ill_op");
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if (obs() !== blank(S_ERROR) || illegal_op !== 1'b1 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL ill_op hold %0d: got ctl=%h ill=%b bus=%b want ctl=%h ill=1 bus=0", i, obs(),
                     illegal_op, bus_err, blank(S_ERROR));
         end
         check_counters("ill_op_hold");
         @(posedge clk); cyc++; #1;
      end
   endtask

   task automatic test_timeout();
      ctl_t c;
      do_reset();
      opcode = 6'b101011;
      build_front(0);
      c = blank(S_MEM_ADDR); c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 4'b0010;
      push(c, 1'b1);
      c = blank(S_MEM_WRITE); c.iord = 1; c.mem_wr = 1;
      repeat (TO) push(c, 1'b0);
      play("timeout");
      n_cmp++;
      if (state !== S_ERROR || bus_err !== 1'b1 || illegal_op !== 1'b0) begin
         n_err++;
         $display("FAIL timeout: got st=%0d bus=%b ill=%b want st=%0d bus=1 ill=0", state, bus_err,
                  illegal_op, S_ERROR);
      end
      check_counters("timeout");
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs() !== blank(S_FETCH) || bus_err !== 0 || illegal_op !== 0 ||
          cycle_cnt !== '0 || instret_cnt !== '0) begin
         n_err++;
         $display("FAIL async_reset: got ctl=%h bus=%b ill=%b cnt=%0d/%0d want ctl=%h zeros", obs(),
                  bus_err, illegal_op, cycle_cnt, instret_cnt, blank(S_FETCH));
      end
      do_reset();
      run_instr("after_reset", 6'b000000, 6'b100010, 5'd1, 5'd7, 1'b0, 1, 0);
   endtask

   task automatic test_reset_mid_instr();
      ctl_t c;
      opcode = 6'b000000; funct = 6'b100101; ir_rd = 5'd12;
      build_front(0);
      c = blank(S_R_EXEC); c.alu_src_a = 1; c.alu_ctrl = 4'b0001; push(c, 1'b1);
      play("mid_reset");
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (state !== S_FETCH || rf_we !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got st=%0d rf_we=%b want st=%0d rf_we=0", state, rf_we, S_FETCH);
      end
      do_reset();
      run_instr("post_mid", 6'b001101, 6'h00, 5'd6, 5'd0, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_illegal_funct();
      test_illegal_op();
      test_timeout();
      test_reset_mid_instr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
